// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: operation codes and FSM states.
package usr_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_SHL   = 3'd2;
  localparam logic [2:0] OP_SHR   = 3'd3;
  localparam logic [2:0] OP_SAR   = 3'd4;
  localparam logic [2:0] OP_ROL   = 3'd5;
  localparam logic [2:0] OP_ROR   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Shifts and rotates are the only ops that may take more than one cycle.
  function automatic logic isShiftOp(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Single one-bit shift/rotate step: next register value and the bit that leaves it.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic [2:0]       op_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] next_o,
  output logic             outBit_o
);

  always_comb begin
    next_o   = val_i;
    outBit_o = 1'b0;
    unique case (op_i)
      OP_SHL: begin
        next_o   = {val_i[WIDTH-2:0], sin_i};
        outBit_o = val_i[WIDTH-1];
      end
      OP_SHR: begin
        next_o   = {sin_i, val_i[WIDTH-1:1]};
        outBit_o = val_i[0];
      end
      OP_SAR: begin
        next_o   = {val_i[WIDTH-1], val_i[WIDTH-1:1]};
        outBit_o = val_i[0];
      end
      OP_ROL: begin
        next_o   = {val_i[WIDTH-2:0], val_i[WIDTH-1]};
        outBit_o = val_i[WIDTH-1];
      end
      OP_ROR: begin
        next_o   = {val_i[0], val_i[WIDTH-1:1]};
        outBit_o = val_i[0];
      end
      default: begin
        next_o   = val_i;
        outBit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit register with load/clear and multi-cycle shifts/rotates driven by a
// start/busy/done handshake; one bit moves per clock while running.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AMT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] i,
  input  logic             sin,
  input  logic             abort,
  output logic [WIDTH-1:0] o,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  logic [0:0]       state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] stepVal;
  logic             stepOut;

  usr_step #(.WIDTH(WIDTH)) stepUnit (
    .val_i    (o_q),
    .op_i     (op_q),
    .sin_i    (sin),
    .next_o   (stepVal),
    .outBit_o (stepOut)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    o_d     = o_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        if (isShiftOp(op) && (amt != '0)) begin
          op_d    = op;
          count_d = amt;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          done_d = 1'b1;
          if (op == OP_LOAD) begin
            o_d = i;
          end else if (op == OP_CLEAR) begin
            o_d    = '0;
            sout_d = 1'b0;
          end
        end
      end
    end else begin
      // Abort beats the step: the partial result stays put and no done is raised.
      if (abort) begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end else begin
        o_d     = stepVal;
        sout_d  = stepOut;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= OP_NOP;
      o_q     <= RESET_VAL;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      o_q     <= o_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o    = o_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
